reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 16, number of entries; power of two.
REQ-002 SHALL have parameter POS_W, default 4, log2(ROB_SIZE).
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-006 SHALL have port issue  input  1  allocate tail entry this edge.
REQ-007 SHALL have ports issue_rd (in 5, destination register), issue_has_rd (in 1, entry writes a register), issue_is_br (in 1, entry is a branch or jump).
REQ-008 SHALL have port issue_rob_pos  output  POS_W  current tail index, for renaming at issue.
REQ-009 SHALL have port full  output  1  no free entry; combinational from count.
REQ-010 SHALL have ports wb_valid (in 1), wb_rob_pos (in POS_W), wb_val (in 32), wb_mispred (in 1), wb_target (in 32): result broadcast.
REQ-011 SHALL have ports qry1_pos/qry2_pos (in POS_W), qry1_ready/qry2_ready (out 1), qry1_val/qry2_val (out 32): operand lookup.
REQ-012 SHALL have ports commit (out 1), commit_rd (out 5), commit_val (out 32), commit_rob_pos (out POS_W): register-file write.
REQ-013 SHALL have ports retire (out 1, head retired), flush (out 1), flush_pc (out 32).

Function
REQ-014 SHALL hold per entry: busy, ready, has_rd, is_br, mispred, rd, val, target; head and tail pointers; count in 0..ROB_SIZE.
REQ-015 full SHALL be 1 iff count == ROB_SIZE; issue while full SHALL be ignored.
REQ-016 Accepted issue SHALL set tail entry busy=1, ready=0, store rd/has_rd/is_br; tail increments mod ROB_SIZE.
REQ-017 wb_valid SHALL set ready=1, val, mispred, target of entry wb_rob_pos only if busy; otherwise ignored.
REQ-018 Query SHALL be combinational: ready/val of the entry, bypassed from wb when wb_valid and wb_rob_pos matches.
REQ-019 At an edge where the head entry is busy and ready, SHALL retire it: clear busy, head increments, outputs registered for the following cycle.
REQ-020 Retire pulse: retire=1 always; commit=1 only if has_rd and rd != 0; commit_rd/commit_val/commit_rob_pos from the entry.
REQ-021 Retire pulses SHALL last exactly one cycle; at most one retire per edge.
REQ-022 Minimum latency: wb at edge E -> retire at edge E+1 -> commit high during cycle after E+1.
REQ-023 Retiring an entry with is_br and mispred SHALL assert flush=1, flush_pc=target for one cycle; clear all busy; head=tail=0, count=0.
REQ-024 Issue in the same edge as a mispredict retire SHALL be discarded.
REQ-025 Simultaneous issue and non-flush retire SHALL leave count unchanged; pointers wrap mod ROB_SIZE.
REQ-026 rdy low SHALL freeze state and drive commit, retire, flush to 0.

Reset
REQ-027 rst SHALL clear all busy/ready bits, head=tail=count=0, full=0.
REQ-028 rst SHALL drive commit=retire=flush=0 and commit_rd/commit_val/commit_rob_pos/flush_pc=0; rst overrides issue, wb and rdy, including mid-operation.

Verification
REQ-029 Issue rd=5 (pos 0), wb pos 0 val 0x1234 -> one cycle commit=1, commit_rd=5, commit_val=0x1234, commit_rob_pos=0.
REQ-030 Issue 16 entries, no wb -> full=1; 17th issue ignored; wb pos 0 -> after retire full=0.
REQ-031 Issue A,B; wb B then A -> retire A strictly before B, commit_rob_pos 0 then 1.
REQ-032 Branch at pos 2, wb mispred target 0x80 -> flush=1, flush_pc=0x80; next cycle issue_rob_pos=0, full=0.
REQ-033 Entry issue_has_rd=0 or rd=0 -> retire=1, commit=0.
REQ-034 wb pos 3 same cycle as qry1_pos=3 -> qry1_ready=1, qry1_val=wb_val.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation, out-of-order writeback, in-order
// retirement with one registered commit/retire/flush pulse per edge.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int POS_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue,
  input  logic [4:0]       issue_rd,
  input  logic             issue_has_rd,
  input  logic             issue_is_br,
  output logic [POS_W-1:0] issue_rob_pos,
  output logic             full,
  input  logic             wb_valid,
  input  logic [POS_W-1:0] wb_rob_pos,
  input  logic [31:0]      wb_val,
  input  logic             wb_mispred,
  input  logic [31:0]      wb_target,
  input  logic [POS_W-1:0] qry1_pos,
  input  logic [POS_W-1:0] qry2_pos,
  output logic             qry1_ready,
  output logic             qry2_ready,
  output logic [31:0]      qry1_val,
  output logic [31:0]      qry2_val,
  output logic             commit,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_val,
  output logic [POS_W-1:0] commit_rob_pos,
  output logic             retire,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  logic [ROB_SIZE-1:0] busy, ready, has_rd_q, is_br_q, mispred_q;
  logic [4:0]          rd_q     [ROB_SIZE];
  logic [31:0]         val_q    [ROB_SIZE];
  logic [31:0]         target_q [ROB_SIZE];
  logic [POS_W-1:0]    head, tail;
  logic [POS_W:0]      count;

  logic             commit_q, retire_q, flush_q;
  logic [4:0]       commit_rd_q;
  logic [31:0]      commit_val_q, flush_pc_q;
  logic [POS_W-1:0] commit_pos_q;

  logic do_retire, do_flush, do_issue, wb_hit;

  assign full          = (count == (POS_W+1)'(ROB_SIZE));
  assign issue_rob_pos = tail;

  always_comb begin
    do_retire = busy[head] & ready[head];
    do_flush  = do_retire & is_br_q[head] & mispred_q[head];
    do_issue  = issue & ~full & ~do_flush;
    wb_hit    = wb_valid & busy[wb_rob_pos];
  end

  assign qry1_ready = (wb_valid && wb_rob_pos == qry1_pos) | ready[qry1_pos];
  assign qry2_ready = (wb_valid && wb_rob_pos == qry2_pos) | ready[qry2_pos];
  assign qry1_val   = (wb_valid && wb_rob_pos == qry1_pos) ? wb_val : val_q[qry1_pos];
  assign qry2_val   = (wb_valid && wb_rob_pos == qry2_pos) ? wb_val : val_q[qry2_pos];

  // Pulses are registered, then masked so a stalled cycle never shows one.
  assign commit         = commit_q & rdy;
  assign retire         = retire_q & rdy;
  assign flush          = flush_q & rdy;
  assign commit_rd      = commit_rd_q;
  assign commit_val     = commit_val_q;
  assign commit_rob_pos = commit_pos_q;
  assign flush_pc       = flush_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      ready        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_q     <= 1'b0;
      retire_q     <= 1'b0;
      flush_q      <= 1'b0;
      commit_rd_q  <= '0;
      commit_val_q <= '0;
      commit_pos_q <= '0;
      flush_pc_q   <= '0;
    end else if (rdy) begin
      commit_q <= do_retire & has_rd_q[head] & (rd_q[head] != '0);
      retire_q <= do_retire;
      flush_q  <= do_flush;
      if (do_retire) begin
        commit_rd_q  <= rd_q[head];
        commit_val_q <= val_q[head];
        commit_pos_q <= head;
      end
      if (do_flush) flush_pc_q <= target_q[head];
      if (wb_hit) begin
        ready[wb_rob_pos]     <= 1'b1;
        val_q[wb_rob_pos]     <= wb_val;
        mispred_q[wb_rob_pos] <= wb_mispred;
        target_q[wb_rob_pos]  <= wb_target;
      end
      if (do_flush) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_retire) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        // A busy tail only exists when full, so issue never collides with wb or retire.
        if (do_issue) begin
          busy[tail]     <= 1'b1;
          ready[tail]    <= 1'b0;
          rd_q[tail]     <= issue_rd;
          has_rd_q[tail] <= issue_has_rd;
          is_br_q[tail]  <= issue_is_br;
          tail           <= tail + 1'b1;
        end
        count <= count + {{POS_W{1'b0}}, do_issue} - {{POS_W{1'b0}}, do_retire};
      end
    end else begin
      commit_q <= 1'b0;
      retire_q <= 1'b0;
      flush_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand-written corner sequences,
// and randomized traffic against a program-order queue model.
module tb_reorder_buffer;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, issue, issue_has_rd, issue_is_br;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_pos;
  logic        full;
  logic        wb_valid, wb_mispred;
  logic [3:0]  wb_rob_pos;
  logic [31:0] wb_val, wb_target;
  logic [3:0]  qry1_pos, qry2_pos;
  logic        qry1_ready, qry2_ready;
  logic [31:0] qry1_val, qry2_val;
  logic        commit, retire, flush;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val, flush_pc;
  logic [3:0]  commit_rob_pos;

  int checks = 0;
  int failures = 0;

  reorder_buffer #(.ROB_SIZE(16), .POS_W(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue(issue), .issue_rd(issue_rd), .issue_has_rd(issue_has_rd),
    .issue_is_br(issue_is_br), .issue_rob_pos(issue_rob_pos), .full(full),
    .wb_valid(wb_valid), .wb_rob_pos(wb_rob_pos), .wb_val(wb_val),
    .wb_mispred(wb_mispred), .wb_target(wb_target),
    .qry1_pos(qry1_pos), .qry2_pos(qry2_pos), .qry1_ready(qry1_ready),
    .qry2_ready(qry2_ready), .qry1_val(qry1_val), .qry2_val(qry2_val),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_pos(commit_rob_pos), .retire(retire), .flush(flush),
    .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  // Program-order model: front of the queue is the oldest in-flight entry.
  typedef struct {
    logic [3:0]  pos;
    logic [4:0]  rd;
    logic        hrd, br, rdy, mp;
    logic [31:0] val, tgt;
  } ent_t;
  ent_t mq[$];
  int   m_tail;

  typedef struct {
    logic        iss;
    logic [4:0]  rd;
    logic        hrd, wbv;
    logic [3:0]  wbp;
    logic [31:0] wbval;
    logic [3:0]  tail;
    logic        ret, com;
    logic [4:0]  erd;
    logic [31:0] eval;
    logic [3:0]  epos;
  } vec_t;
  vec_t vecs[14];

  function automatic vec_t mk(input int iss, input int rd, input int hrd, input int wbv,
                              input int wbp, input int wbval, input int tail, input int ret,
                              input int com, input int erd, input int eval, input int epos);
    vec_t v;
    v.iss = 1'(iss); v.rd = 5'(rd); v.hrd = 1'(hrd); v.wbv = 1'(wbv);
    v.wbp = 4'(wbp); v.wbval = 32'(wbval); v.tail = 4'(tail); v.ret = 1'(ret);
    v.com = 1'(com); v.erd = 5'(erd); v.eval = 32'(eval); v.epos = 4'(epos);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue = 1'b0; issue_rd = '0; issue_has_rd = 1'b0; issue_is_br = 1'b0;
    wb_valid = 1'b0; wb_rob_pos = '0; wb_val = '0; wb_mispred = 1'b0; wb_target = '0;
    qry1_pos = '0; qry2_pos = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic hrd, input logic br);
    issue = 1'b1; issue_rd = rd; issue_has_rd = hrd; issue_is_br = br;
    tick();
    issue = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; idle();
    tick(); tick();
    rst = 1'b0;
    mq.delete(); m_tail = 0;
  endtask

  task automatic qchk(input string nm, input logic [3:0] p, input logic ra, input logic [31:0] va);
    if (wb_valid && wb_rob_pos == p) begin
      chk({nm, "_ready_byp"}, 32'(ra), 32'd1);
      chk({nm, "_val_byp"}, va, wb_val);
    end else begin
      foreach (mq[i]) if (mq[i].pos == p) begin
        chk({nm, "_ready"}, 32'(ra), 32'(mq[i].rdy));
        if (mq[i].rdy) chk({nm, "_val"}, va, mq[i].val);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        er, ec, ef;
    logic [4:0]  erd;
    logic [31:0] ev, epc;
    logic [3:0]  ep;
    int          sz;
    ent_t        e;

    do_reset();
    chk("rst_commit", 32'(commit), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_tail", 32'(issue_rob_pos), 0);
    chk("rst_commit_rd", 32'(commit_rd), 0);
    chk("rst_commit_val", commit_val, 0);
    chk("rst_flush_pc", flush_pc, 0);

    // Basic commit, out-of-order writeback, and no-destination entries.
    vecs[0]  = mk(1, 5, 1, 0, 0, 0,       0, 0, 0, 0, 0,       0);
    vecs[1]  = mk(0, 0, 0, 1, 0, 'h1234,  1, 0, 0, 0, 0,       0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0,       1, 1, 1, 5, 'h1234,  0);
    vecs[3]  = mk(1, 1, 1, 0, 0, 0,       1, 0, 0, 0, 0,       0);
    vecs[4]  = mk(1, 2, 1, 0, 0, 0,       2, 0, 0, 0, 0,       0);
    vecs[5]  = mk(0, 0, 0, 1, 2, 'hB,     3, 0, 0, 0, 0,       0);
    vecs[6]  = mk(0, 0, 0, 1, 1, 'hA,     3, 0, 0, 0, 0,       0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0,       3, 1, 1, 1, 'hA,     1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,       3, 1, 1, 2, 'hB,     2);
    vecs[9]  = mk(1, 7, 0, 0, 0, 0,       3, 0, 0, 0, 0,       0);
    vecs[10] = mk(1, 0, 1, 0, 0, 0,       4, 0, 0, 0, 0,       0);
    vecs[11] = mk(0, 0, 0, 1, 3, 'h33,    5, 0, 0, 0, 0,       0);
    vecs[12] = mk(0, 0, 0, 1, 4, 'h44,    5, 1, 0, 7, 'h33,    3);
    vecs[13] = mk(0, 0, 0, 0, 0, 0,       5, 1, 0, 0, 'h44,    4);
    for (int i = 0; i < 14; i++) begin
      issue = vecs[i].iss; issue_rd = vecs[i].rd; issue_has_rd = vecs[i].hrd; issue_is_br = 1'b0;
      wb_valid = vecs[i].wbv; wb_rob_pos = vecs[i].wbp; wb_val = vecs[i].wbval;
      wb_mispred = 1'b0; wb_target = '0;
      #1;
      chk($sformatf("v%0d_tail", i), 32'(issue_rob_pos), 32'(vecs[i].tail));
      chk($sformatf("v%0d_full", i), 32'(full), 0);
      tick();
      chk($sformatf("v%0d_retire", i), 32'(retire), 32'(vecs[i].ret));
      chk($sformatf("v%0d_commit", i), 32'(commit), 32'(vecs[i].com));
      chk($sformatf("v%0d_flush", i), 32'(flush), 0);
      if (vecs[i].ret) begin
        chk($sformatf("v%0d_commit_rd", i), 32'(commit_rd), 32'(vecs[i].erd));
        chk($sformatf("v%0d_commit_val", i), commit_val, vecs[i].eval);
        chk($sformatf("v%0d_commit_pos", i), 32'(commit_rob_pos), 32'(vecs[i].epos));
      end
    end
    idle();

    // Fill to capacity; the 17th issue must not move the tail.
    do_reset();
    for (int i = 0; i < N; i++) do_issue(5'(i + 1), 1'b1, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_tail_wrap", 32'(issue_rob_pos), 0);
    do_issue(5'd31, 1'b1, 1'b0);
    chk("fill_17th_tail", 32'(issue_rob_pos), 0);
    chk("fill_17th_full", 32'(full), 1);
    wb_valid = 1'b1; wb_rob_pos = 4'd0; wb_val = 32'h55;
    tick();
    idle();
    chk("fill_no_early_retire", 32'(retire), 0);
    tick();
    chk("fill_retire", 32'(retire), 1);
    chk("fill_retire_pos", 32'(commit_rob_pos), 0);
    chk("fill_retire_rd", 32'(commit_rd), 1);
    chk("fill_not_full", 32'(full), 0);
    tick();
    chk("fill_retire_one_cycle", 32'(retire), 0);

    // Mispredicted branch at pos 2 with an issue attempt on the flush edge.
    do_reset();
    do_issue(5'd1, 1'b1, 1'b0);
    do_issue(5'd2, 1'b1, 1'b0);
    do_issue(5'd0, 1'b0, 1'b1);
    do_issue(5'd3, 1'b1, 1'b0);
    wb_valid = 1'b1; wb_rob_pos = 4'd0; wb_val = 32'h10; tick();
    wb_rob_pos = 4'd1; wb_val = 32'h11; tick();
    chk("br_retire0", 32'(retire), 1);
    wb_rob_pos = 4'd2; wb_val = 32'h12; wb_mispred = 1'b1; wb_target = 32'h80; tick();
    chk("br_retire1_pos", 32'(commit_rob_pos), 1);
    chk("br_no_flush_yet", 32'(flush), 0);
    idle();
    issue = 1'b1; issue_rd = 5'd9; issue_has_rd = 1'b1;
    tick();
    issue = 1'b0;
    chk("br_flush", 32'(flush), 1);
    chk("br_flush_pc", flush_pc, 32'h80);
    chk("br_retire", 32'(retire), 1);
    chk("br_commit", 32'(commit), 0);
    chk("br_tail_zero", 32'(issue_rob_pos), 0);
    chk("br_not_full", 32'(full), 0);
    wb_valid = 1'b1; wb_rob_pos = 4'd3; wb_val = 32'h13;
    tick();
    idle();
    chk("br_flush_one_cycle", 32'(flush), 0);
    tick();
    chk("br_flushed_entry_gone", 32'(retire), 0);

    // Same-cycle writeback bypass onto the query port.
    do_reset();
    for (int i = 0; i < 4; i++) do_issue(5'(i + 1), 1'b1, 1'b0);
    wb_valid = 1'b1; wb_rob_pos = 4'd3; wb_val = 32'hCAFE; qry1_pos = 4'd3; qry2_pos = 4'd2;
    #1;
    chk("byp_ready", 32'(qry1_ready), 1);
    chk("byp_val", qry1_val, 32'hCAFE);
    chk("byp_other_not_ready", 32'(qry2_ready), 0);
    tick();
    wb_valid = 1'b0; qry2_pos = 4'd3;
    #1;
    chk("stored_ready", 32'(qry2_ready), 1);
    chk("stored_val", qry2_val, 32'hCAFE);

    // Randomized traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(7) != 0);
      issue = 1'($urandom_range(1)); issue_rd = 5'($urandom);
      issue_has_rd = ($urandom_range(3) != 0); issue_is_br = ($urandom_range(3) == 0);
      if (mq.size() > 0 && $urandom_range(2) != 0) begin
        wb_valid = 1'b1;
        wb_rob_pos = mq[$urandom_range(mq.size() - 1)].pos;
      end else begin
        wb_valid = ($urandom_range(3) == 0);
        wb_rob_pos = 4'($urandom);
      end
      wb_val = $urandom; wb_mispred = ($urandom_range(5) == 0); wb_target = $urandom;
      qry1_pos = $urandom_range(1) ? wb_rob_pos : 4'($urandom);
      qry2_pos = 4'($urandom);
      #1;
      sz = mq.size();
      chk("rnd_full", 32'(full), 32'(sz == N));
      chk("rnd_tail", 32'(issue_rob_pos), 32'(m_tail));
      qchk("rnd_q1", qry1_pos, qry1_ready, qry1_val);
      qchk("rnd_q2", qry2_pos, qry2_ready, qry2_val);

      er = 1'b0; ec = 1'b0; ef = 1'b0; erd = '0; ev = '0; ep = '0; epc = '0;
      if (rdy) begin
        if (sz > 0 && mq[0].rdy) begin
          er = 1'b1;
          ec = mq[0].hrd && (mq[0].rd != 0);
          erd = mq[0].rd; ev = mq[0].val; ep = mq[0].pos;
          ef = mq[0].br && mq[0].mp;
          epc = mq[0].tgt;
        end
        if (wb_valid) begin
          foreach (mq[i]) if (mq[i].pos == wb_rob_pos) begin
            mq[i].rdy = 1'b1; mq[i].val = wb_val; mq[i].mp = wb_mispred; mq[i].tgt = wb_target;
          end
        end
        if (er) void'(mq.pop_front());
        if (ef) begin
          mq.delete();
          m_tail = 0;
        end else if (issue && sz < N) begin
          e.pos = 4'(m_tail); e.rd = issue_rd; e.hrd = issue_has_rd; e.br = issue_is_br;
          e.rdy = 1'b0; e.mp = 1'b0; e.val = '0; e.tgt = '0;
          mq.push_back(e);
          m_tail = (m_tail + 1) % N;
        end
      end
      tick();
      chk("rnd_retire", 32'(retire), 32'(er));
      chk("rnd_commit", 32'(commit), 32'(ec));
      chk("rnd_flush", 32'(flush), 32'(ef));
      if (er) begin
        chk("rnd_commit_rd", 32'(commit_rd), 32'(erd));
        chk("rnd_commit_val", commit_val, ev);
        chk("rnd_commit_pos", 32'(commit_rob_pos), 32'(ep));
      end
      if (ef) chk("rnd_flush_pc", flush_pc, epc);
    end

    // Reset in mid-operation overrides issue, wb and rdy.
    rst = 1'b1; rdy = 1'b1; issue = 1'b1; wb_valid = 1'b1;
    tick();
    rst = 1'b0; idle();
    #1;
    chk("midrst_retire", 32'(retire), 0);
    chk("midrst_commit", 32'(commit), 0);
    chk("midrst_flush", 32'(flush), 0);
    chk("midrst_commit_val", commit_val, 0);
    chk("midrst_commit_pos", 32'(commit_rob_pos), 0);
    chk("midrst_flush_pc", flush_pc, 0);
    chk("midrst_tail", 32'(issue_rob_pos), 0);
    chk("midrst_full", 32'(full), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
